// File: rtl/mux5_scanner_if.sv
// mux5_scanner_if
//   Bundles the signals between the scanner, the 5:1 mux it drives, and the
//   downstream frame consumer.
//   master : the scanner. It drives sel, data_out, out_valid and busy.
//            It receives start, mux_y and out_ready.
//   slave  : the environment, which is the mux plus the frame consumer.
//   Signals:
//     start     : request one scan
//     sel[2:0]  : mux select, 0..4
//     mux_y     : selected mux output
//     data_out  : assembled 5-bit frame
//     out_valid : frame available
//     out_ready : consumer accepts the frame
//     busy      : scan in progress
interface mux5_scanner_if;
  logic       start;
  logic [2:0] sel;
  logic       mux_y;
  logic [4:0] data_out;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  modport master (
    input  start, mux_y, out_ready,
    output sel, data_out, out_valid, busy
  );

  modport slave (
    output start, mux_y, out_ready,
    input  sel, data_out, out_valid, busy
  );
endinterface

// File: rtl/mux5_scanner.sv
// mux5_scanner
//   Steps a 5:1 mux select through channels 0..4. Each channel is held for
//   DWELL cycles, and mux_y is sampled at the last edge of that window. The
//   five samples form a frame, which is presented on a valid/ready
//   handshake. Bit k of the frame is the sample taken with sel = k.
//   Parameters:
//     DWELL      : cycles per channel, 1..16
//     CONTINUOUS : 1 = rescan automatically after each accepted frame
//   Ports:
//     clk : rising-edge clock
//     rst : asynchronous active-high reset
//     bus : mux5_scanner_if.master
//           start, sel, mux_y, data_out, out_valid, out_ready, busy
module mux5_scanner #(
  parameter int DWELL      = 1,
  parameter int CONTINUOUS = 0
) (
  input  logic            clk,
  input  logic            rst,
  mux5_scanner_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } state_t;

  localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);
  localparam logic [2:0] LAST_CH    = 3'd4;

  state_t     state;
  logic [2:0] ch;
  logic [3:0] cnt;
  logic [3:0] shadow;

  // NOTE: every state register is written with <=. All reads in this block
  // therefore see values from before the edge, which matches how the
  // hardware behaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: shadow is a small register, not a memory, so it is cleared
      // along with the rest of the state. A partial frame never leaks out
      // after a reset.
      state         <= IDLE;
      ch            <= '0;
      cnt           <= '0;
      shadow        <= '0;
      bus.sel       <= '0;
      bus.data_out  <= '0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= SCAN;
            ch       <= '0;
            cnt      <= '0;
            bus.sel  <= '0;
            bus.busy <= 1'b1;
          end
        end

        SCAN: begin
          // start is deliberately not looked at here, so a request made
          // during a scan does not queue.
          if (cnt < DWELL_LAST) begin
            cnt <= cnt + 4'd1;
          end else if (ch < LAST_CH) begin
            shadow[ch[1:0]] <= bus.mux_y;
            ch              <= ch + 3'd1;
            cnt             <= '0;
            bus.sel         <= ch + 3'd1;   // sel tracks ch while scanning
          end else begin
            // The last channel goes straight into the frame, so no fifth
            // shadow bit is needed.
            bus.data_out  <= {bus.mux_y, shadow};
            bus.out_valid <= 1'b1;
            bus.busy      <= 1'b0;
            bus.sel       <= '0;
            state         <= HOLD;
          end
        end

        HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if ((CONTINUOUS != 0) || bus.start) begin
              state    <= SCAN;
              ch       <= '0;
              cnt      <= '0;
              bus.busy <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux5_scanner.sv
// tb_mux5_scanner
//   Four scanner instances are built with different DWELL/CONTINUOUS
//   settings, and each one reads its own bench-side mux pattern. Stimulus
//   pushes the expected frame and its absolute valid cycle into a
//   scoreboard. A single monitor pops an entry on every out_valid rise and
//   compares it with what the DUT presented.
module tb_mux5_scanner;

  localparam int NI = 4;
  localparam int DW [NI] = '{1, 3, 2, 16};
  localparam int CT [NI] = '{0, 0, 1, 0};

  typedef struct {
    int         inst;
    logic [4:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic       start_v [NI];
  logic       ready_v [NI];
  logic [4:0] pat     [NI];
  logic [2:0] sel_w   [NI];
  logic [4:0] data_w  [NI];
  logic       valid_w [NI];
  logic       busy_w  [NI];

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mux5_scanner_if bus ();
    assign bus.start     = start_v[g];
    assign bus.out_ready = ready_v[g];
    assign bus.mux_y     = pat[g][bus.sel];
    assign sel_w[g]      = bus.sel;
    assign data_w[g]     = bus.data_out;
    assign valid_w[g]    = bus.out_valid;
    assign busy_w[g]     = bus.busy;

    mux5_scanner #(.DWELL(DW[g]), .CONTINUOUS(CT[g])) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge. The pulse is seen at the next rising edge, E0.
  task automatic pulse_start(input int g, output int e0);
    start_v[g] = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    start_v[g] = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic expect_frame(input int g, input logic [4:0] d, input int c);
    exp_t e;
    e.inst = g;
    e.data = d;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag, input int g);
    check({tag, " sel"},   32'(sel_w[g]),   32'd0);
    check({tag, " data"},  32'(data_w[g]),  32'd0);
    check({tag, " valid"}, 32'(valid_w[g]), 32'd0);
    check({tag, " busy"},  32'(busy_w[g]),  32'd0);
  endtask

  // Monitor: frame check on each valid rise, and a stability check while
  // a frame is held.
  logic       prev_valid [NI];
  logic [4:0] held       [NI];
  initial for (int g = 0; g < NI; g++) prev_valid[g] = 1'b0;

  always @(negedge clk) begin
    int idx;
    for (int g = 0; g < NI; g++) begin
      check("sel range", 32'(sel_w[g] <= 3'd4), 32'd1);
      if (valid_w[g] === 1'b1 && prev_valid[g] !== 1'b1) begin
        idx = -1;
        foreach (sb[j]) if (idx < 0 && sb[j].inst == g) idx = j;
        if (idx < 0) begin
          check("unexpected frame", 32'd1, 32'd0);
        end else begin
          check("frame data", 32'(data_w[g]), 32'(sb[idx].data));
          check("valid cycle", 32'(cyc), 32'(sb[idx].cyc));
          held[g] = sb[idx].data;
          sb.delete(idx);
        end
      end else if (valid_w[g] === 1'b1) begin
        check("held data", 32'(data_w[g]), 32'(held[g]));
      end
      if (valid_w[g] === 1'b1) check("busy in hold", 32'(busy_w[g]), 32'd0);
      prev_valid[g] = valid_w[g];
    end
  end

  initial begin
    int e0;
    for (int g = 0; g < NI; g++) begin
      start_v[g] = 1'b0;
      ready_v[g] = 1'b1;
      pat[g]     = 5'b00000;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < NI; g++) check_reset_outputs("reset", g);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: DWELL=1, single scan, sel steps 0..4, one-cycle valid
    pat[0] = 5'b10110;
    pulse_start(0, e0);
    expect_frame(0, 5'b10110, e0 + 5);
    for (int k = 0; k < 5; k++) begin
      check("t1 sel", 32'(sel_w[0]), 32'(k));
      check("t1 busy", 32'(busy_w[0]), 32'd1);
      @(negedge clk);
    end
    @(negedge clk);
    check("t1 valid drop", 32'(valid_w[0]), 32'd0);
    check("t1 idle sel", 32'(sel_w[0]), 32'd0);
    check("t1 data kept", 32'(data_w[0]), 32'b10110);
    repeat (3) @(negedge clk);

    // Test 2: DWELL=3, each sel value held three cycles
    pat[1] = 5'b01001;
    pulse_start(1, e0);
    expect_frame(1, 5'b01001, e0 + 15);
    for (int k = 0; k < 5; k++)
      for (int d = 0; d < 3; d++) begin
        check("t2 sel", 32'(sel_w[1]), 32'(k));
        @(negedge clk);
      end
    repeat (3) @(negedge clk);

    // Test 3: back-pressure, input change in HOLD, start ignored in SCAN
    ready_v[0] = 1'b0;
    pat[0] = 5'b01101;
    pulse_start(0, e0);
    expect_frame(0, 5'b01101, e0 + 5);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_until(e0 + 7);
    pat[0] = 5'b11111;
    wait_until(e0 + 15);
    check("t3 still valid", 32'(valid_w[0]), 32'd1);
    check("t3 old frame", 32'(data_w[0]), 32'b01101);
    ready_v[0] = 1'b1;
    @(negedge clk);
    check("t3 accepted", 32'(valid_w[0]), 32'd0);
    check("t3 idle busy", 32'(busy_w[0]), 32'd0);
    check("t3 data kept", 32'(data_w[0]), 32'b01101);
    repeat (8) @(negedge clk);
    check("t3 no extra scan", 32'(busy_w[0]), 32'd0);

    // Test 4: CONTINUOUS=1, DWELL=2, frames every 11 cycles
    pat[2] = 5'b00001;
    pulse_start(2, e0);
    expect_frame(2, 5'b00001, e0 + 10);
    expect_frame(2, 5'b10000, e0 + 21);
    wait_until(e0 + 10);
    pat[2] = 5'b10000;
    wait_until(e0 + 21);
    ready_v[2] = 1'b0;
    repeat (4) @(negedge clk);
    check("t4 hold parked", 32'(valid_w[2]), 32'd1);

    // Test 5: async reset mid-SCAN (sel=2) and in HOLD, then a clean frame
    pat[1] = 5'b11010;
    pulse_start(1, e0);
    wait_until(e0 + 6);
    check("t5 sel before rst", 32'(sel_w[1]), 32'd2);
    #1 rst = 1'b1;
    #1 check_reset_outputs("t5 scan rst", 1);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    ready_v[1] = 1'b0;
    pat[1] = 5'b10101;
    pulse_start(1, e0);
    expect_frame(1, 5'b10101, e0 + 15);
    wait_until(e0 + 17);
    #1 rst = 1'b1;
    #1 check_reset_outputs("t5 hold rst", 1);
    #1 rst = 1'b0;
    ready_v[1] = 1'b1;
    @(negedge clk);
    pat[1] = 5'b01110;
    pulse_start(1, e0);
    expect_frame(1, 5'b01110, e0 + 15);
    wait_until(e0 + 18);

    // Test 6: DWELL=16, walking one, 80-cycle latency
    for (int w = 0; w < 5; w++) begin
      pat[3] = 5'b00001 << w;
      pulse_start(3, e0);
      expect_frame(3, 5'b00001 << w, e0 + 80);
      wait_until(e0 + 82);
    end

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
